// File: rtl/branch_comp_iter.sv
// Multi-cycle branch comparator: compares CHUNK_W bits per cycle, MSB chunk first,
// behind a valid/ready handshake on both the request and the result side.
module branch_comp_iter #(
    parameter int DATA_W     = 32,
    parameter int CHUNK_W    = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_rs1_data,
    input  logic [DATA_W-1:0] i_rs2_data,
    input  logic              i_br_un,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_br_eq,
    output logic              o_br_lt
);
    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};

    generate
        if (DATA_W % CHUNK_W != 0) begin : g_bad_chunk
            $error("branch_comp_iter: DATA_W must be a multiple of CHUNK_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  a_q, b_q;
    logic [CNT_W-1:0]   cnt;
    logic               eq_q, lt_q;
    logic [CHUNK_W-1:0] a_chk, b_chk;
    logic [31:0]        sel;
    logic               accept, chk_ne, last;

    assign accept = i_valid && o_ready;

    always_comb begin
        sel    = 32'(NCHUNK - 1) - 32'(cnt);
        a_chk  = a_q[sel*CHUNK_W +: CHUNK_W];
        b_chk  = b_q[sel*CHUNK_W +: CHUNK_W];
        chk_ne = (a_chk != b_chk);
        last   = (cnt == CNT_W'(NCHUNK - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CMP;
            CMP:  if (last || (EARLY_EXIT != 0 && chk_ne)) state_nxt = DONE;
            DONE: if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == DONE);
        o_br_eq = eq_q;
        o_br_lt = lt_q;
    end

    // Signed compare becomes unsigned by flipping the sign bit of both operands at capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q  <= '0;
            b_q  <= '0;
            cnt  <= '0;
            eq_q <= 1'b0;
            lt_q <= 1'b0;
        end else if (accept) begin
            a_q  <= i_rs1_data ^ (i_br_un ? '0 : SIGN_BIT);
            b_q  <= i_rs2_data ^ (i_br_un ? '0 : SIGN_BIT);
            cnt  <= '0;
            eq_q <= 1'b1;
            lt_q <= 1'b0;
        end else if (state == CMP) begin
            if (!last) cnt <= cnt + 1'b1;
            // Only the most significant differing chunk decides the ordering.
            if (eq_q && chk_ne) begin
                eq_q <= 1'b0;
                lt_q <= (a_chk < b_chk);
            end
        end
    end
endmodule

// File: tb/tb_branch_comp_iter.sv
// Bench for branch_comp_iter: spec vectors, back-pressure/reset sequences and random requests
// on three configurations (early exit, full scan, single chunk).
module tb_branch_comp_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  vld, rdy_in;
    logic [31:0] rs1, rs2;
    logic        un_r;
    wire  [2:0]  rdy_out, ov, eq, lt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    branch_comp_iter #(.DATA_W(32), .CHUNK_W(8), .EARLY_EXIT(1)) dut_ee (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[0]), .o_ready(rdy_out[0]),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(un_r), .o_valid(ov[0]),
        .i_ready(rdy_in[0]), .o_br_eq(eq[0]), .o_br_lt(lt[0]));

    branch_comp_iter #(.DATA_W(32), .CHUNK_W(8), .EARLY_EXIT(0)) dut_fs (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[1]), .o_ready(rdy_out[1]),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(un_r), .o_valid(ov[1]),
        .i_ready(rdy_in[1]), .o_br_eq(eq[1]), .o_br_lt(lt[1]));

    branch_comp_iter #(.DATA_W(32), .CHUNK_W(32), .EARLY_EXIT(1)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[2]), .o_ready(rdy_out[2]),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(un_r), .o_valid(ov[2]),
        .i_ready(rdy_in[2]), .o_br_eq(eq[2]), .o_br_lt(lt[2]));

    typedef struct {
        int          d;
        logic [31:0] a, b;
        logic        un, xeq, xlt;
        int          xm;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer compare; latency = chunks examined under each configuration.
    function automatic int ref_m(input int d, input logic [31:0] a, input logic [31:0] b);
        if (d == 1) return 4;
        if (d == 2) return 1;
        for (int i = 0; i < 4; i++)
            if (a[31-8*i -: 8] != b[31-8*i -: 8]) return i + 1;
        return 4;
    endfunction

    function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b, input logic un);
        return un ? (a < b) : ($signed(a) < $signed(b));
    endfunction

    task automatic run_req(input int d, input logic [31:0] a, input logic [31:0] b, input logic un,
                           input logic xeq, input logic xlt, input int xm, input int hold);
        int k;
        rs1 = a; rs2 = b; un_r = un; vld[d] = 1'b1;
        chk("ready_idle", 32'(rdy_out[d]), 32'd1);
        @(posedge clk); #1;
        vld[d] = 1'b0;
        rs1 = $urandom; rs2 = $urandom; un_r = ~un;
        k = 0;
        while (!ov[d] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 32'(k), 32'(xm));
        chk("eq", 32'(eq[d]), 32'(xeq));
        chk("lt", 32'(lt[d]), 32'(xlt));
        chk("ready_busy", 32'(rdy_out[d]), 32'd0);
        repeat (hold) begin @(posedge clk); #1; end
        if (hold > 0) chk("hold_valid", 32'(ov[d]), 32'd1);
        rdy_in[d] = 1'b1;
        @(posedge clk); #1;
        rdy_in[d] = 1'b0;
        chk("release_valid", 32'(ov[d]), 32'd0);
        chk("release_ready", 32'(rdy_out[d]), 32'd1);
    endtask

    initial begin
        vec_t vecs[$];
        logic [31:0] a, b;
        logic        un;
        int          k, d, hold;

        vecs.push_back('{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 4});
        vecs.push_back('{0, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 4});
        vecs.push_back('{1, 32'h0000_0001, 32'h8000_0001, 1'b1, 1'b0, 1'b1, 4});
        vecs.push_back('{0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{0, 32'h1200_00FF, 32'h1200_0100, 1'b1, 1'b0, 1'b1, 3});
        vecs.push_back('{1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 4});
        vecs.push_back('{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{2, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1});

        rst = 1'b1; vld = '0; rdy_in = '0; rs1 = '0; rs2 = '0; un_r = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", 32'(rdy_out[i]), 32'd1);
            chk("rst_valid", 32'(ov[i]), 32'd0);
            chk("rst_eq", 32'(eq[i]), 32'd0);
            chk("rst_lt", 32'(lt[i]), 32'd0);
        end

        foreach (vecs[i])
            run_req(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].un,
                    vecs[i].xeq, vecs[i].xlt, vecs[i].xm, i % 2);

        // Back-pressure in DONE with a competing request held on i_valid.
        rs1 = 32'h8000_0000; rs2 = 32'h7FFF_FFFF; un_r = 1'b0; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        k = 0;
        while (!ov[0] && k < 20) begin @(posedge clk); #1; k++; end
        chk("bp_latency", 32'(k), 32'd1);
        vld[0] = 1'b1; rs1 = 32'h0; rs2 = 32'h0; un_r = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(ov[0]), 32'd1);
            chk("bp_eq", 32'(eq[0]), 32'd0);
            chk("bp_lt", 32'(lt[0]), 32'd1);
            chk("bp_ready", 32'(rdy_out[0]), 32'd0);
        end
        rdy_in[0] = 1'b1; vld[0] = 1'b0;
        @(posedge clk); #1;
        rdy_in[0] = 1'b0;
        chk("bp_rel_valid", 32'(ov[0]), 32'd0);
        chk("bp_rel_ready", 32'(rdy_out[0]), 32'd1);
        @(posedge clk); #1;
        chk("bp_no_queue", 32'(ov[0]), 32'd0);

        // Reset in the middle of a full-length compare drops the transaction.
        rs1 = 32'h1234_5678; rs2 = 32'h1234_5678; un_r = 1'b1; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", 32'(ov[0]), 32'd0);
        chk("mid_rst_ready", 32'(rdy_out[0]), 32'd1);
        chk("mid_rst_eq", 32'(eq[0]), 32'd0);
        chk("mid_rst_lt", 32'(lt[0]), 32'd0);
        repeat (4) @(posedge clk);
        #1 chk("mid_rst_dropped", 32'(ov[0]), 32'd0);
        run_req(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b1, 4, 0);

        // Random requests against the integer reference model.
        for (int n = 0; n < 10600; n++) begin
            d = (n < 10000) ? 0 : ((n < 10300) ? 1 : 2);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            un = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_req(d, a, b, un, (a == b), ref_lt(a, b, un), ref_m(d, a, b), hold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
